// File: rtl/alu_seq_unit.sv
// Registered ALU with ALUOP/FUNCTION decode: single-cycle logic/arith ops plus
// iterative unsigned shift-add multiply and restoring divide behind START/BUSY/DONE.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       ALUOP,
    input  logic [5:0]       FUNCTION,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] HI,
    output logic             ZERO,
    output logic             DIV0,
    output logic             ILLEGAL
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_NOP, OP_ILL
    } op_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;
    logic             illegal_q, illegal_d;

    op_t              op;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH-1:0] div_hi, div_lo;
    logic             div_qbit;

    always_comb begin
        op = OP_ILL;
        if (ALUOP == 3'b010) begin
            case (FUNCTION)
                6'b100000: op = OP_ADD;
                6'b100010: op = OP_SUB;
                6'b100100: op = OP_AND;
                6'b100101: op = OP_OR;
                6'b101010: op = OP_SLT;
                6'b011000: op = OP_MUL;
                6'b011010: op = OP_DIV;
                6'b000000: op = OP_NOP;
                default:   op = OP_ILL;
            endcase
        end else begin
            case (ALUOP)
                3'b011:  op = OP_ADD;
                3'b100:  op = OP_SUB;
                3'b111:  op = OP_AND;
                3'b101:  op = OP_OR;
                3'b001:  op = OP_SLT;
                default: op = OP_ILL;
            endcase
        end
    end

    always_comb begin
        sc_res = '0;
        case (op)
            OP_ADD:  sc_res = A + B;
            OP_SUB:  sc_res = A - B;
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: sc_res = '0;
        endcase
    end

    // Multiply: {acc_hi, acc_lo} starts as {0, A}; add B into the top when the LSB is set, then shift right.
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
    always_comb begin
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_qbit  = ~div_trial[WIDTH];
        div_hi    = div_qbit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo    = {acc_lo_q[WIDTH-2:0], div_qbit};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        hi_d      = hi_q;
        zero_d    = zero_q;
        div0_d    = div0_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (op == OP_MUL || (op == OP_DIV && B != '0)) begin
                        state_d  = (op == OP_MUL) ? S_MUL : S_DIV;
                        cnt_d    = CNT_LOAD;
                        acc_hi_d = '0;
                        acc_lo_d = A;
                        opb_d    = B;
                        busy_d   = 1'b1;
                    end else if (op == OP_DIV) begin
                        done_d    = 1'b1;
                        result_d  = '1;
                        hi_d      = A;
                        zero_d    = 1'b0;
                        div0_d    = 1'b1;
                        illegal_d = 1'b0;
                    end else begin
                        done_d    = 1'b1;
                        result_d  = sc_res;
                        hi_d      = '0;
                        zero_d    = (sc_res == '0);
                        div0_d    = 1'b0;
                        illegal_d = (op == OP_ILL);
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_hi_d = (state_q == S_MUL) ? mul_hi : div_hi;
                acc_lo_d = (state_q == S_MUL) ? mul_lo : div_lo;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    result_d  = acc_lo_d;
                    hi_d      = acc_hi_d;
                    zero_d    = (acc_lo_d == '0);
                    div0_d    = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b1;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            zero_q    <= zero_d;
            div0_q    <= div0_d;
            illegal_q <= illegal_d;
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RESULT  = result_q;
    assign HI      = hi_q;
    assign ZERO    = zero_q;
    assign DIV0    = div0_q;
    assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit at WIDTH 4, 8 and 32: directed steps plus a random
// sweep, with expected completions queued on issue and checked on DONE.
module tb_alu_seq_unit;

    typedef struct {
        int          sel;
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        div0;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start;
    logic [2:0]  aluop;
    logic [5:0]  func;
    logic [31:0] a_in, b_in;

    logic [3:0]  res4, hi4;
    logic [7:0]  res8, hi8;
    logic [31:0] res32, hi32;
    logic [2:0]  o_busy, o_done, o_zero, o_div0, o_ill;
    logic [31:0] o_res [3];
    logic [31:0] o_hi  [3];

    assign o_res[0] = {28'd0, res4};
    assign o_res[1] = {24'd0, res8};
    assign o_res[2] = res32;
    assign o_hi[0]  = {28'd0, hi4};
    assign o_hi[1]  = {24'd0, hi8};
    assign o_hi[2]  = hi32;

    int   wid [3] = '{4, 8, 32};
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   done_cnt = 0;
    exp_t scb [$];
    exp_t em;
    logic [8:0] tbl [13] = '{
        9'b010_100000, 9'b010_100010, 9'b010_100100, 9'b010_100101, 9'b010_101010,
        9'b010_011000, 9'b010_011010, 9'b010_000000, 9'b011_000000, 9'b100_000000,
        9'b001_000000, 9'b110_000000, 9'b010_111111
    };

    alu_seq_unit #(.WIDTH(4)) u_w4 (
        .CLK(clk), .RST(rst), .START(start[0]), .ALUOP(aluop), .FUNCTION(func),
        .A(a_in[3:0]), .B(b_in[3:0]), .BUSY(o_busy[0]), .DONE(o_done[0]),
        .RESULT(res4), .HI(hi4), .ZERO(o_zero[0]), .DIV0(o_div0[0]), .ILLEGAL(o_ill[0]));

    alu_seq_unit #(.WIDTH(8)) u_w8 (
        .CLK(clk), .RST(rst), .START(start[1]), .ALUOP(aluop), .FUNCTION(func),
        .A(a_in[7:0]), .B(b_in[7:0]), .BUSY(o_busy[1]), .DONE(o_done[1]),
        .RESULT(res8), .HI(hi8), .ZERO(o_zero[1]), .DIV0(o_div0[1]), .ILLEGAL(o_ill[1]));

    alu_seq_unit #(.WIDTH(32)) u_w32 (
        .CLK(clk), .RST(rst), .START(start[2]), .ALUOP(aluop), .FUNCTION(func),
        .A(a_in), .B(b_in), .BUSY(o_busy[2]), .DONE(o_done[2]),
        .RESULT(res32), .HI(hi32), .ZERO(o_zero[2]), .DIV0(o_div0[2]), .ILLEGAL(o_ill[2]));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int i, input logic [2:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] m, aa, bb, p;
        longint      sa_v, sb_v;
        int          w, k;
        w = wid[i];
        m = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & m;
        bb = {32'd0, b} & m;
        e.sel = i; e.res = '0; e.hi = '0; e.div0 = 1'b0; e.ill = 1'b0; e.lat = 0; e.acc = 0;
        k = 8;
        if (op == 3'b010) begin
            case (fn)
                6'b100000: k = 0;
                6'b100010: k = 1;
                6'b100100: k = 2;
                6'b100101: k = 3;
                6'b101010: k = 4;
                6'b011000: k = 5;
                6'b011010: k = 6;
                6'b000000: k = 7;
                default:   k = 8;
            endcase
        end else begin
            case (op)
                3'b011:  k = 0;
                3'b100:  k = 1;
                3'b111:  k = 2;
                3'b101:  k = 3;
                3'b001:  k = 4;
                default: k = 8;
            endcase
        end
        case (k)
            0: e.res = 32'((aa + bb) & m);
            1: e.res = 32'((aa - bb) & m);
            2: e.res = 32'(aa & bb);
            3: e.res = 32'(aa | bb);
            4: begin
                sa_v = aa[w-1] ? longint'(aa) - longint'(m) - 1 : longint'(aa);
                sb_v = bb[w-1] ? longint'(bb) - longint'(m) - 1 : longint'(bb);
                e.res = (sa_v < sb_v) ? 32'd1 : 32'd0;
            end
            5: begin
                p = aa * bb;
                e.res = 32'(p & m);
                e.hi  = 32'((p >> w) & m);
                e.lat = w;
            end
            6: begin
                if (bb == 64'd0) begin
                    e.res = 32'(m); e.hi = 32'(aa); e.div0 = 1'b1;
                end else begin
                    e.res = 32'(aa / bb); e.hi = 32'(aa % bb); e.lat = w;
                end
            end
            8: e.ill = 1'b1;
            default: e.res = '0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input int i, input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        n = 0;
        start = '0;
        while (o_busy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("busy_timeout", 64'(o_busy[i]), 64'd0);
        aluop = op; func = fn; a_in = a; b_in = b;
        start[i] = 1'b1;
        e = model(i, op, fn, a, b);
        e.acc = cyc + 1;
        scb.push_back(e);
        acc_cnt++;
        @(negedge clk);
        start = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (scb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (scb.size() != 0) chk("drain_timeout", 64'(scb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_done[i]) begin
                done_cnt++;
                if (scb.size() == 0) begin
                    chk("unexpected_done", 64'(o_done[i]), 64'd0);
                end else begin
                    em = scb.pop_front();
                    chk("sb_dut", 64'(i), 64'(em.sel));
                    chk("sb_result", 64'(o_res[i]), 64'(em.res));
                    chk("sb_hi", 64'(o_hi[i]), 64'(em.hi));
                    chk("sb_zero", 64'(o_zero[i]), 64'(em.zero));
                    chk("sb_div0", 64'(o_div0[i]), 64'(em.div0));
                    chk("sb_illegal", 64'(o_ill[i]), 64'(em.ill));
                    chk("sb_busy", 64'(o_busy[i]), 64'd0);
                    chk("sb_latency", 64'(cyc - em.acc), 64'(em.lat));
                end
            end
        end
    end

    initial begin
        logic [8:0] ent;
        logic [31:0] ra, rb;
        rst = 1'b1; start = '0; aluop = '0; func = '0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 64'(o_busy[i]), 64'd0);
            chk("rst_done", 64'(o_done[i]), 64'd0);
            chk("rst_result", 64'(o_res[i]), 64'd0);
            chk("rst_hi", 64'(o_hi[i]), 64'd0);
            chk("rst_zero", 64'(o_zero[i]), 64'd1);
            chk("rst_div0", 64'(o_div0[i]), 64'd0);
            chk("rst_illegal", 64'(o_ill[i]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        issue(1, 3'b010, 6'b100000, 32'hF0, 32'h20);
        chk("add_done", 64'(o_done[1]), 64'd1);
        chk("add_result", 64'(o_res[1]), 64'h10);
        chk("add_hi", 64'(o_hi[1]), 64'd0);
        chk("add_zero", 64'(o_zero[1]), 64'd0);

        issue(1, 3'b001, 6'b000000, 32'h80, 32'h01);
        chk("slt_result", 64'(o_res[1]), 64'd1);
        @(negedge clk);
        chk("done_one_cycle", 64'(o_done[1]), 64'd0);

        issue(1, 3'b010, 6'b011000, 32'hFF, 32'hFF);
        chk("mul_busy_start", 64'(o_busy[1]), 64'd1);
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            chk("mul_busy_hold", 64'(o_busy[1]), 64'd1);
            chk("mul_no_early_done", 64'(o_done[1]), 64'd0);
            start[1] = (j == 2 || j == 5);
            aluop = 3'b011; a_in = 32'h11; b_in = 32'h22;
        end
        @(negedge clk);
        chk("mul_done", 64'(o_done[1]), 64'd1);
        chk("mul_result", 64'(o_res[1]), 64'h01);
        chk("mul_hi", 64'(o_hi[1]), 64'hFE);
        @(negedge clk);

        issue(1, 3'b010, 6'b011010, 32'd200, 32'd7);
        drain();
        chk("div_result", 64'(o_res[1]), 64'd28);
        chk("div_hi", 64'(o_hi[1]), 64'd4);

        issue(1, 3'b010, 6'b011010, 32'h55, 32'h0);
        chk("div0_done", 64'(o_done[1]), 64'd1);
        chk("div0_busy", 64'(o_busy[1]), 64'd0);
        chk("div0_result", 64'(o_res[1]), 64'hFF);
        chk("div0_hi", 64'(o_hi[1]), 64'h55);
        chk("div0_flag", 64'(o_div0[1]), 64'd1);

        issue(1, 3'b000, 6'b000000, 32'h12, 32'h34);
        chk("ill_done", 64'(o_done[1]), 64'd1);
        chk("ill_flag", 64'(o_ill[1]), 64'd1);
        chk("ill_result", 64'(o_res[1]), 64'd0);
        issue(1, 3'b011, 6'b000000, 32'h3, 32'h4);
        chk("b2b_done", 64'(o_done[1]), 64'd1);
        chk("b2b_result", 64'(o_res[1]), 64'h7);
        chk("b2b_ill_clear", 64'(o_ill[1]), 64'd0);

        issue(1, 3'b010, 6'b011000, 32'h5A, 32'h3C);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(scb.pop_back());
        acc_cnt--;
        chk("mrst_busy", 64'(o_busy[1]), 64'd0);
        chk("mrst_done", 64'(o_done[1]), 64'd0);
        chk("mrst_result", 64'(o_res[1]), 64'd0);
        chk("mrst_hi", 64'(o_hi[1]), 64'd0);
        chk("mrst_zero", 64'(o_zero[1]), 64'd1);
        chk("mrst_div0", 64'(o_div0[1]), 64'd0);
        chk("mrst_illegal", 64'(o_ill[1]), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue(1, 3'b010, 6'b100000, 32'h21, 32'h05);
        chk("post_rst_result", 64'(o_res[1]), 64'h26);
        drain();

        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 25; n++) begin
                ent = tbl[$urandom_range(0, 12)];
                ra = $urandom;
                rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
                issue(i, ent[8:6], ent[5:0], ra, rb);
            end
            drain();
        end

        repeat (3) @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'(acc_cnt));
        chk("queue_empty", 64'(scb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered successor to the ALU control decoder. Decodes the same ALUOP/FUNCTION encodings and executes the selected operation on WIDTH-bit operands. Single-cycle ops complete in one clock; mul and div run as iterative multi-cycle operations behind a START/BUSY/DONE handshake. Sits between the decode stage and write-back; the pipeline stalls while BUSY is high.

## Interface
- WIDTH, 32: operand/result width, ≥ 4.
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; accepted on a rising edge when BUSY=0.
- ALUOP  in  3  op class from main control.
- FUNCTION  in  6  R-type function field; used only when ALUOP=3'b010.
- A, B  in  WIDTH  operands; sampled only on acceptance.
- BUSY  out  1  multi-cycle op in progress.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  WIDTH  low result / quotient.
- HI  out  WIDTH  mul high half / div remainder; 0 for other ops.
- ZERO  out  1  RESULT==0, updated with RESULT.
- DIV0  out  1  last completed op was div with B=0.
- ILLEGAL  out  1  last accepted request had an undecoded ALUOP/FUNCTION.

## Operation
- Decode, ALUOP=010:
  - Arithmetic/logic: FUNCTION 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Multi-cycle: 011000 mul, 011010 div.
  - No-op: 000000 nop.
- Decode, other ALUOP values: 011 add, 100 sub, 111 and, 101 or, 001 slt.
- Any other encoding is illegal. It completes like a single-cycle op with RESULT=0, HI=0, ILLEGAL=1.
- Arithmetic:
  - add and sub wrap modulo 2^WIDTH.
  - slt is a signed two's-complement compare; RESULT is 1 or 0.
  - mul and div are unsigned. mul gives the 2·WIDTH product: RESULT is the low half, HI the high half.
  - div uses restoring division: RESULT is the quotient, HI the remainder.
  - nop gives RESULT=0.
- Div by zero is detected at acceptance and completes in one cycle with RESULT = all ones, HI=A, DIV0=1.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL or DIV on an accepted mul or div with B≠0. Operands are latched, the iteration counter is loaded with WIDTH, and BUSY is set.
  - MUL and DIV each perform one shift-add or shift-subtract step per clock and decrement the counter.
  - On the final step (counter reaching 0), the FSM returns to IDLE: RESULT, HI, ZERO and DIV0 are written, DONE pulses, BUSY clears.
- Single-cycle ops never leave IDLE.
- START while BUSY=1 is ignored: no queueing, no effect on the running op.
- RESULT, HI, ZERO, DIV0 and ILLEGAL hold their values until the next completion. ILLEGAL and DIV0 are cleared by any legal completion.
- A and B may change freely after acceptance.

## Timing
- Reset: at a rising edge with RST=1:
  - State goes to IDLE and the counter to 0.
  - BUSY, DONE, RESULT, HI, DIV0 and ILLEGAL go to 0; ZERO goes to 1.
  - RST overrides START.
- Reset mid-operation aborts the op with no DONE pulse.
- Single-cycle op (including nop, illegal, div-by-zero) accepted at edge k: DONE=1 and outputs valid after edge k; BUSY stays 0.
- mul/div accepted at edge k: BUSY=1 from edge k; DONE=1 and BUSY=0 after edge k+WIDTH. Latency is WIDTH cycles.
- DONE is high for exactly one cycle per accepted request.
- Since BUSY=0 in the DONE cycle, a new START is accepted on that same edge, giving back-to-back operation with no bubble.
- Throughput: one single-cycle op per clock.

## Test plan
- Reset, then single-cycle ops at WIDTH=8:
  - ALUOP=010, FUNCTION=100000, A=8'hF0, B=8'h20 → DONE after one edge, RESULT=8'h10, HI=0, ZERO=0.
  - ALUOP=001, A=8'h80, B=8'h01 → RESULT=1 (signed slt).
- Multiply at WIDTH=8:
  - mul, A=8'hFF, B=8'hFF → BUSY for 8 cycles, DONE on the 8th edge, HI=8'hFE, RESULT=8'h01.
  - START pulses during BUSY are ignored.
- Divide at WIDTH=8:
  - div, A=8'd200, B=8'd7 → RESULT=8'd28, HI=8'd4 after 8 cycles.
  - div, B=0, A=8'h55 → DONE after one edge, RESULT=8'hFF, HI=8'h55, DIV0=1, BUSY never set.
- Illegal and back-to-back:
  - ALUOP=000 → ILLEGAL=1, RESULT=0, DONE after one edge.
  - Next, a legal add issued in the DONE cycle → accepted, and ILLEGAL clears on its completion.
- Reset mid-mul: assert RST at cycle 4 of 8 → BUSY=0 and all outputs at reset values on the next edge, no DONE pulse. A subsequent add completes normally.
- Sweep WIDTH=4/8/32 with random operands → every op matches a reference model, DONE count equals accepted START count, and mul/div latency is exactly WIDTH.
